eng_uc_queue: RTL
=================

// Module: eng_uc_queue
// PURPOSE
//  Per-engine implied-unit-clause queue: the producer side of the UC arbiter's eng2uca_* interface.
//  Engine pushes implied literals; arbiter reads head (min/valid/empty) and pops. One instance per engine.
//  Two orders: FIFO (mask mode) or ascending priority queue (PQ mode), so head is always the pop candidate.
// PARAMETERS
//  DEPTH       8    entries held; power of two, >=2
//  CNT_W       $clog2(DEPTH)+1   occupancy counter width (derived, localparam)
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous, active-high reset
//  input_mode     in   1      0 = FIFO order, 1 = ascending-literal PQ order
//  eng_push       in   1      engine pushes eng_lit this cycle
//  eng_lit        in   lit_t  implied literal; 0 is reserved/invalid
//  flush          in   1      discard all entries (engine backtrack)
//  uca2ucq_pop    in   1      arbiter consumes head this cycle
//  ucq2uca_min    out  lit_t  head entry (min in PQ mode, oldest in FIFO mode)
//  ucq2uca_valid  out  1      head holds a valid literal (= !empty)
//  ucq2uca_empty  out  1      no entries
//  ucq2uca_full   out  1      count == DEPTH
//  ucq_count      out  CNT_W  occupancy
//  ucq_overflow   out  1      sticky: a push was dropped
// BEHAVIOUR
//  - Only one clock (clk); reset is synchronous and active-high on rst.
//  - Reset: count=0, all entries 0, min=0, valid=0, empty=1, full=0, overflow=0, mode_r=0.
//  - Storage: shift array ent[0..DEPTH-1], ent[0] = head; outputs driven from registers, no comb path input->output.
//  - Latency: pushed literal visible on outputs the cycle after eng_push; pop removes head, next entry visible next cycle.
//  - Mode: mode_r <= input_mode only when queue empty (and not being pushed); while non-empty input_mode is ignored.
//  - FIFO insert: at index count (after pop shift if popping). PQ insert: at first index whose entry > eng_lit
//    (unsigned compare of lit_t bits), entries at/after shift up; ties insert after existing equals (stable).
//  - Pop when empty: ignored, no state change. Push with eng_lit==0: ignored.
//  - Full, push, no pop: push dropped, ucq_overflow set (sticky until rst or flush).
//  - Full, push and pop same cycle: head removed, new literal inserted; count unchanged.
//  - Push+pop on empty: pop ignored, push accepted (count 1).
//  - Push+pop when count==1: result holds only the new literal.
//  - flush: highest priority; count=0, entries zeroed, overflow cleared; same-cycle push/pop ignored.
//  - Count arithmetic: count_next = count + push_acc - pop_acc, never wraps (guarded above).
// CONFIGURATION
//  UCQ_DEDUP_EN defined: push of a literal already present (or equal to one inserted same cycle) is dropped
//    silently, no overflow, unless the matching entry is the head being popped that cycle (then accepted).
//  UCQ_DEDUP_EN undefined: duplicates stored as separate entries; no match comparators built.
// STRUCTURE
//  - Shared package: lit_t (already defined), `LIT_IDX_MAX, `NUM_ENGINE; add localparam UCQ_DEPTH_DEFAULT=8.
//  - One sub-module natural: ucq_insert_pos -- comb, given entries/count/lit/mode returns insert index
//    (and dup hit when UCQ_DEDUP_EN); top module owns registers, count, flags.
// TESTING
//  - FIFO: mode 0, push 7,3,5 -> min 7,3,5 on successive pops; empty=1 after third pop; count 3->0.
//  - PQ: mode 1, push 9,2,6,2 -> pops yield 2,2,6,9; min=2 one cycle after push of 2.
//  - Full: DEPTH=8 fill, push 11 -> dropped, overflow=1, count 8; push 11+pop same cycle -> count 8, 11 present.
//  - Mode latch: mode 0 with 2 entries, switch input_mode=1, push 1 -> appended at tail (FIFO); after drain mode_r=1.
//  - Flush/reset mid-op: 5 entries, flush with push -> count 0, empty 1, overflow 0; rst mid-fill -> all reset values.
//  - UCQ_DEDUP_EN: push 4,4 -> count 1; pop head 4 with push 4 same cycle -> count 1, min 4.

Source files
------------

// File: rtl/eng_uc_queue_pkg.sv
// Shared types and defaults for the per-engine implied-unit-clause queue.
// Contents:
//   LIT_W              literal width in bits
//   lit_t              literal type; value 0 is reserved as "no literal"
//   UCQ_DEPTH_DEFAULT  default queue depth
package eng_uc_queue_pkg;

    localparam int unsigned LIT_W = 8;

    typedef logic [LIT_W-1:0] lit_t;

    localparam int unsigned UCQ_DEPTH_DEFAULT = 8;

endpackage

// File: rtl/eng_uc_queue_insert_pos.sv
// Insert-position finder for eng_uc_queue (purely combinational).
// It operates on the queue as it will look after any same-cycle pop.
// Optional feature macro: UCQ_DEDUP_EN (builds the duplicate-match comparators).
// Ports:
//   entries  in   lit_t x DEPTH  queue contents, index 0 = head, unused slots are 0
//   count    in   CNT_W          number of valid entries in entries
//   lit      in   lit_t          literal to insert
//   mode     in   1              0 = FIFO (tail insert), 1 = ascending priority order
//   pos      out  CNT_W          index at which lit goes (0..count)
//   dup      out  1              lit already present (always 0 without UCQ_DEDUP_EN)
module eng_uc_queue_insert_pos
    import eng_uc_queue_pkg::*;
#(
    parameter int unsigned DEPTH = UCQ_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  lit_t             entries [DEPTH],
    input  logic [CNT_W-1:0] count,
    input  lit_t             lit,
    input  logic             mode,
    output logic [CNT_W-1:0] pos,
    output logic             dup
);

    // Entries are kept sorted in PQ mode, so the lowest index holding a
    // strictly larger literal is the insert point; equal literals stay ahead
    // of the new one, which keeps ties stable.
    always_comb begin
        pos = count;
        if (mode) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if ((CNT_W'(i) < count) && (entries[i] > lit)) begin
                    pos = CNT_W'(i);
                end
            end
        end
    end

`ifdef UCQ_DEDUP_EN
    always_comb begin
        dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count) && (entries[i] == lit)) begin
                dup = 1'b1;
            end
        end
    end
`else
    assign dup = 1'b0;
`endif

endmodule

// File: rtl/eng_uc_queue.sv
// Per-engine implied-unit-clause queue feeding the UC arbiter.
// The engine pushes implied literals; the arbiter reads the head and pops it.
// The queue runs in FIFO order or in ascending-literal priority order, so the
// head is always the next pop candidate. All outputs come straight from registers.
// Optional feature macro: UCQ_DEDUP_EN (drop pushes of literals already queued).
// Ports:
//   clk            in   1      clock
//   rst            in   1      synchronous active-high reset
//   input_mode     in   1      0 = FIFO, 1 = ascending PQ; latched only while empty
//   eng_push       in   1      push eng_lit this cycle
//   eng_lit        in   lit_t  literal to push; 0 is ignored
//   flush          in   1      discard all entries, clear overflow (wins over push/pop)
//   uca2ucq_pop    in   1      remove head this cycle
//   ucq2uca_min    out  lit_t  head entry (0 when empty)
//   ucq2uca_valid  out  1      queue non-empty
//   ucq2uca_empty  out  1      queue empty
//   ucq2uca_full   out  1      count == DEPTH
//   ucq_count      out  CNT_W  occupancy
//   ucq_overflow   out  1      sticky: a push was dropped because the queue was full
module eng_uc_queue
    import eng_uc_queue_pkg::*;
#(
    parameter int unsigned DEPTH = UCQ_DEPTH_DEFAULT,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             input_mode,
    input  logic             eng_push,
    input  lit_t             eng_lit,
    input  logic             flush,
    input  logic             uca2ucq_pop,
    output lit_t             ucq2uca_min,
    output logic             ucq2uca_valid,
    output logic             ucq2uca_empty,
    output logic             ucq2uca_full,
    output logic [CNT_W-1:0] ucq_count,
    output logic             ucq_overflow
);

    lit_t             ent_q [DEPTH];
    lit_t             ent_d [DEPTH];
    lit_t             ent_s [DEPTH];  // contents after any same-cycle pop
    logic [CNT_W-1:0] count_q, count_d, count_s;
    logic [CNT_W-1:0] ins_pos;
    logic             mode_q, mode_d;
    logic             ovf_q, ovf_d;
    logic             pop_acc, push_req, push_acc, dup_hit, room;

    always_comb begin
        pop_acc  = uca2ucq_pop && (count_q != '0) && !flush;
        push_req = eng_push && (eng_lit != '0) && !flush;
    end

    // Apply the pop first so insertion sees the queue the arbiter leaves behind;
    // a full queue that is popped therefore still has room for the push.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            ent_s[i] = pop_acc ? ent_q[i+1] : ent_q[i];
        end
        ent_s[DEPTH-1] = pop_acc ? '0 : ent_q[DEPTH-1];
        count_s = count_q - {{(CNT_W-1){1'b0}}, pop_acc};
    end

    eng_uc_queue_insert_pos #(
        .DEPTH (DEPTH)
    ) u_insert_pos (
        .entries (ent_s),
        .count   (count_s),
        .lit     (eng_lit),
        .mode    (mode_q),
        .pos     (ins_pos),
        .dup     (dup_hit)
    );

    always_comb begin
        room     = (count_s != CNT_W'(DEPTH));
        push_acc = push_req && !dup_hit && room;
    end

    // Next-state: shift entries at/after the insert point up by one.
    always_comb begin
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_d[i] = '0;
            end
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            ent_d[0] = (push_acc && (ins_pos == '0)) ? eng_lit : ent_s[0];
            for (int i = 1; i < DEPTH; i++) begin
                if (!push_acc || (CNT_W'(i) < ins_pos)) begin
                    ent_d[i] = ent_s[i];
                end else if (CNT_W'(i) == ins_pos) begin
                    ent_d[i] = eng_lit;
                end else begin
                    ent_d[i] = ent_s[i-1];
                end
            end
            count_d = count_s + {{(CNT_W-1){1'b0}}, push_acc};
            ovf_d   = ovf_q | (push_req && !dup_hit && !room);
        end
    end

    // Order may only change while nothing is queued, so stored entries never
    // mix orderings.
    always_comb begin
        mode_d = mode_q;
        if ((count_q == '0) && !push_acc) begin
            mode_d = input_mode;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            count_q <= '0;
            mode_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            count_q <= count_d;
            mode_q  <= mode_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ucq2uca_min   = ent_q[0];
    assign ucq2uca_valid = (count_q != '0);
    assign ucq2uca_empty = (count_q == '0);
    assign ucq2uca_full  = (count_q == CNT_W'(DEPTH));
    assign ucq_count     = count_q;
    assign ucq_overflow  = ovf_q;

endmodule
